// File: rtl/alu_pkg.sv
// Shared op-code definitions for the pipelined ALU.
// Imported by alu_core and pipelined_alu.
package alu_pkg;

  typedef logic [2:0] op_t;

  localparam op_t OP_AND  = 3'b000;
  localparam op_t OP_OR   = 3'b001;
  localparam op_t OP_ADD  = 3'b010;
  localparam op_t OP_XOR  = 3'b011;
  localparam op_t OP_NOR  = 3'b100;
  localparam op_t OP_SLTU = 3'b101;
  localparam op_t OP_SUB  = 3'b110;
  localparam op_t OP_SLT  = 3'b111;

  // SUB and SLT share the inverted-b adder path
  function automatic logic op_binv(input op_t op);
    return op[2] & op[1];
  endfunction

endpackage

// File: rtl/alu_core.sv
// Combinational WIDTH-bit ALU: logic ops, add/sub,
// signed/unsigned set-less-than with overflow detect.
module alu_core
  import alu_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0] i_a,
  input  logic [WIDTH-1:0] i_b,
  input  op_t              i_op,
  output logic [WIDTH-1:0] o_result,
  output logic             o_set,
  output logic             o_zero,
  output logic             o_overflow
);

  localparam int M = WIDTH - 1;

  logic             w_binv;
  logic [WIDTH-1:0] w_bx;
  logic [WIDTH-1:0] w_sum;
  logic             w_ovf;
  logic             w_lt;
  logic             w_ltu;
  logic [WIDTH-1:0] w_res;
  logic             w_set;
  logic             w_ovf_out;

  assign w_binv = op_binv(i_op);
  assign w_bx   = w_binv ? ~i_b : i_b;
  assign w_sum  = i_a + w_bx + WIDTH'(w_binv);

  // Same-sign operands producing a different-sign sum
  assign w_ovf = (i_a[M] == w_bx[M]) &&
                 (w_sum[M] != i_a[M]);
  assign w_lt  = w_sum[M] ^ w_ovf;
  assign w_ltu = i_a < i_b;

  always_comb begin
    w_res     = '0;
    w_set     = 1'b0;
    w_ovf_out = 1'b0;
    unique case (i_op)
      OP_AND:  w_res = i_a & i_b;
      OP_OR:   w_res = i_a | i_b;
      OP_XOR:  w_res = i_a ^ i_b;
      OP_NOR:  w_res = ~(i_a | i_b);
      OP_ADD: begin
        w_res     = w_sum;
        w_ovf_out = w_ovf;
      end
      OP_SUB: begin
        w_res     = w_sum;
        w_set     = w_lt;
        w_ovf_out = w_ovf;
      end
      OP_SLT: begin
        w_res     = {{M{1'b0}}, w_lt};
        w_set     = w_lt;
        w_ovf_out = w_ovf;
      end
      OP_SLTU: w_res = {{M{1'b0}}, w_ltu};
      default: w_res = '0;
    endcase
  end

  assign o_result   = w_res;
  assign o_set      = w_set;
  assign o_zero     = ~|w_res;
  assign o_overflow = w_ovf_out;

endmodule

// File: rtl/pipelined_alu.sv
// Two-stage valid/ready ALU pipeline: operand register s1,
// result register s2 driving outputs, sticky overflow status.
module pipelined_alu
  import alu_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [2:0]       op,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             set,
  output logic             zero,
  output logic             overflow,
  output logic             ovf_sticky,
  input  logic             ovf_clr
);

  logic             r_s1_valid;
  logic [WIDTH-1:0] r_s1_a;
  logic [WIDTH-1:0] r_s1_b;
  op_t              r_s1_op;

  logic             r_out_valid;
  logic [WIDTH-1:0] r_result;
  logic             r_set;
  logic             r_zero;
  logic             r_ovf;
  logic             r_sticky;

  logic             w_s2_adv;
  logic             w_acc;
  logic             w_out_hs;
  logic [WIDTH-1:0] w_result;
  logic             w_set;
  logic             w_zero;
  logic             w_ovf;

  assign w_s2_adv = r_s1_valid && (!r_out_valid || out_ready);
  assign in_ready = !r_s1_valid || w_s2_adv;
  assign w_acc    = in_valid && in_ready;
  assign w_out_hs = r_out_valid && out_ready;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_s1_valid <= 1'b0;
      r_s1_a     <= '0;
      r_s1_b     <= '0;
      r_s1_op    <= OP_AND;
    end else if (w_acc) begin
      r_s1_valid <= 1'b1;
      r_s1_a     <= a;
      r_s1_b     <= b;
      r_s1_op    <= op_t'(op);
    end else if (w_s2_adv) begin
      r_s1_valid <= 1'b0;
    end
  end

  alu_core #(
    .WIDTH(WIDTH)
  ) u_core (
    .i_a       (r_s1_a),
    .i_b       (r_s1_b),
    .i_op      (r_s1_op),
    .o_result  (w_result),
    .o_set     (w_set),
    .o_zero    (w_zero),
    .o_overflow(w_ovf)
  );

  // s2 holds its beat until the consumer takes it
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_out_valid <= 1'b0;
      r_result    <= '0;
      r_set       <= 1'b0;
      r_zero      <= 1'b1;
      r_ovf       <= 1'b0;
    end else if (w_s2_adv) begin
      r_out_valid <= 1'b1;
      r_result    <= w_result;
      r_set       <= w_set;
      r_zero      <= w_zero;
      r_ovf       <= w_ovf;
    end else if (out_ready) begin
      r_out_valid <= 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_sticky <= 1'b0;
    end else if (w_out_hs && r_ovf) begin
      r_sticky <= 1'b1;
    end else if (ovf_clr) begin
      r_sticky <= 1'b0;
    end
  end

  assign out_valid  = r_out_valid;
  assign result     = r_result;
  assign set        = r_set;
  assign zero       = r_zero;
  assign overflow   = r_ovf;
  assign ovf_sticky = r_sticky;

endmodule

// File: tb/tb_pipelined_alu.sv
// Randomized + directed bench for pipelined_alu (WIDTH 32 and 8)
// against a plain-arithmetic reference model and scoreboard queue.
module tb_pipelined_alu;

  typedef struct {
    logic [31:0] res;
    logic        set;
    logic        zero;
    logic        ovf;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid, in_ready;
  logic [31:0] a, b;
  logic [2:0]  op;
  logic        out_valid, out_ready;
  logic [31:0] result;
  logic        set, zero, overflow, ovf_sticky, ovf_clr;

  logic        in_valid_8, in_ready_8;
  logic [7:0]  a_8, b_8;
  logic [2:0]  op_8;
  logic        out_valid_8, out_ready_8;
  logic [7:0]  result_8;
  logic        set_8, zero_8, overflow_8, ovf_sticky_8, ovf_clr_8;

  int n_chk = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  pipelined_alu #(.WIDTH(32)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .op(op),
    .out_valid(out_valid), .out_ready(out_ready),
    .result(result), .set(set), .zero(zero),
    .overflow(overflow), .ovf_sticky(ovf_sticky),
    .ovf_clr(ovf_clr)
  );

  pipelined_alu #(.WIDTH(8)) dut8 (
    .clk(clk), .rst(rst),
    .in_valid(in_valid_8), .in_ready(in_ready_8),
    .a(a_8), .b(b_8), .op(op_8),
    .out_valid(out_valid_8), .out_ready(out_ready_8),
    .result(result_8), .set(set_8), .zero(zero_8),
    .overflow(overflow_8), .ovf_sticky(ovf_sticky_8),
    .ovf_clr(ovf_clr_8)
  );

  task automatic chk(input string tag,
                     input logic [63:0] got,
                     input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h @%0t",
               tag, got, exp, $time);
    end
  endtask

  // Reference: signed/unsigned integer arithmetic, then wrap
  function automatic exp_t model(input int w,
                                 input logic [31:0] xa,
                                 input logic [31:0] xb,
                                 input logic [2:0] xop);
    exp_t e;
    longint full = longint'(1) << w;
    longint half = full / 2;
    longint ua = longint'(xa) & (full - 1);
    longint ub = longint'(xb) & (full - 1);
    longint sa = (ua >= half) ? ua - full : ua;
    longint sb = (ub >= half) ? ub - full : ub;
    longint r = 0;
    longint t;
    e.set = 1'b0;
    e.ovf = 1'b0;
    case (xop)
      3'd0: r = ua & ub;
      3'd1: r = ua | ub;
      3'd3: r = ua ^ ub;
      3'd4: r = ~(ua | ub) & (full - 1);
      3'd2: begin
        t = sa + sb;
        r = (ua + ub) & (full - 1);
        e.ovf = (t >= half) || (t < -half);
      end
      3'd6: begin
        t = sa - sb;
        r = (ua - ub) & (full - 1);
        e.ovf = (t >= half) || (t < -half);
        e.set = sa < sb;
      end
      3'd7: begin
        t = sa - sb;
        r = (sa < sb) ? 1 : 0;
        e.ovf = (t >= half) || (t < -half);
        e.set = sa < sb;
      end
      default: r = (ua < ub) ? 1 : 0;
    endcase
    e.res  = 32'(r);
    e.zero = (r == 0);
    return e;
  endfunction

  logic        drv_valid = 0, drv_ordy = 1, drv_clr = 0;
  logic [31:0] drv_a = 0, drv_b = 0;
  logic [2:0]  drv_op = 0;
  exp_t        drv_exp;
  exp_t        q[$];
  logic        m_sticky = 0;
  logic        hold_pend = 0;
  logic [31:0] hold_res = 0;
  logic        last_acc, last_rdy, last_ov;

  task automatic step();
    exp_t e;
    logic hs, e_ovf;
    @(negedge clk);
    chk("sticky", ovf_sticky, m_sticky);
    if (hold_pend) begin
      chk("hold_valid", out_valid, 1'b1);
      chk("hold_result", result, hold_res);
    end
    in_valid  = drv_valid;
    a         = drv_a;
    b         = drv_b;
    op        = drv_op;
    out_ready = drv_ordy;
    ovf_clr   = drv_clr;
    #1;
    last_acc = in_valid && in_ready;
    last_rdy = in_ready;
    last_ov  = out_valid;
    hs = out_valid && out_ready;
    e_ovf = 1'b0;
    if (hs) begin
      chk("sb_nonempty", q.size() != 0, 1'b1);
      if (q.size() != 0) begin
        e = q.pop_front();
        e_ovf = e.ovf;
        chk("result", result, e.res);
        chk("set", set, e.set);
        chk("zero", zero, e.zero);
        chk("overflow", overflow, e.ovf);
      end
    end
    if (hs && e_ovf) m_sticky = 1'b1;
    else if (ovf_clr) m_sticky = 1'b0;
    if (last_acc) q.push_back(drv_exp);
    hold_pend = out_valid && !out_ready;
    hold_res  = result;
  endtask

  task automatic drain();
    int n = 0;
    drv_valid = 0;
    drv_ordy  = 1;
    while ((q.size() != 0 || out_valid) && n < 30) begin
      step();
      n++;
    end
    chk("drain_empty", q.size(), 0);
  endtask

  task automatic single(input logic [31:0] xa,
                        input logic [31:0] xb,
                        input logic [2:0] xop,
                        input exp_t e);
    int n = 0;
    drv_valid = 1;
    drv_a = xa; drv_b = xb; drv_op = xop;
    drv_exp = e;
    drv_ordy = 1;
    do begin
      step();
      n++;
    end while (!last_acc && n < 20);
    chk("accept", last_acc, 1'b1);
    drv_valid = 0;
    step();
    chk("lat_n1_valid", last_ov, 1'b0);
    step();
    chk("lat_n2_valid", last_ov, 1'b1);
    step();
  endtask

  task automatic run8(input logic [7:0] xa,
                      input logic [7:0] xb,
                      input logic [2:0] xop,
                      input exp_t e);
    int n = 0;
    @(negedge clk);
    in_valid_8 = 1; a_8 = xa; b_8 = xb; op_8 = xop;
    out_ready_8 = 1;
    @(negedge clk);
    in_valid_8 = 0;
    while (!out_valid_8 && n < 6) begin
      @(negedge clk);
      n++;
    end
    chk("w8_valid", out_valid_8, 1'b1);
    chk("w8_result", result_8, e.res[7:0]);
    chk("w8_set", set_8, e.set);
    chk("w8_zero", zero_8, e.zero);
    chk("w8_overflow", overflow_8, e.ovf);
  endtask

  function automatic logic [31:0] pick();
    case ($urandom_range(0, 5))
      0: return 32'h0;
      1: return 32'h1;
      2: return 32'h7FFF_FFFF;
      3: return 32'h8000_0000;
      4: return 32'hFFFF_FFFF;
      default: return $urandom;
    endcase
  endfunction

  function automatic exp_t mk(input logic [31:0] r,
                              input logic s, input logic z,
                              input logic o);
    exp_t e;
    e.res = r; e.set = s; e.zero = z; e.ovf = o;
    return e;
  endfunction

  initial begin
    int c;
    int sent;
    rst = 0;
    in_valid = 0; a = 0; b = 0; op = 0;
    out_ready = 1; ovf_clr = 0;
    in_valid_8 = 0; a_8 = 0; b_8 = 0; op_8 = 0;
    out_ready_8 = 1; ovf_clr_8 = 0;
    #1 rst = 1;
    #2;
    chk("rst_out_valid", out_valid, 1'b0);
    chk("rst_result", result, 32'h0);
    chk("rst_set", set, 1'b0);
    chk("rst_zero", zero, 1'b1);
    chk("rst_overflow", overflow, 1'b0);
    chk("rst_sticky", ovf_sticky, 1'b0);
    chk("rst_in_ready", in_ready, 1'b1);
    @(negedge clk);
    rst = 0;

    single(32'h7FFF_FFFF, 32'h1, 3'd2,
           mk(32'h8000_0000, 0, 0, 1));
    chk("sticky_after_add", ovf_sticky, 1'b1);
    single(32'd5, 32'd5, 3'd6, mk(32'h0, 0, 1, 0));
    single(32'hFFFF_FFFF, 32'h1, 3'd7, mk(32'h1, 1, 0, 0));
    single(32'hFFFF_FFFF, 32'h1, 3'd5, mk(32'h0, 0, 1, 0));

    drv_ordy = 0;
    drv_valid = 1;
    for (int i = 0; i < 2; i++) begin
      drv_a = $urandom; drv_b = $urandom; drv_op = 3'd2;
      drv_exp = model(32, drv_a, drv_b, drv_op);
      step();
    end
    @(negedge clk);
    #3 rst = 1;
    in_valid = 0;
    #1;
    chk("async_out_valid", out_valid, 1'b0);
    chk("async_zero", zero, 1'b1);
    chk("async_sticky", ovf_sticky, 1'b0);
    q.delete();
    m_sticky = 0;
    hold_pend = 0;
    drv_valid = 0;
    drv_ordy = 1;
    #20 rst = 0;
    repeat (6) step();
    chk("no_stale", out_valid, 1'b0);

    c = 0;
    sent = 0;
    while ((sent < 8) && c < 100) begin
      drv_valid = 1;
      drv_ordy = !(c >= 3 && c < 6);
      drv_a = $urandom; drv_b = $urandom;
      drv_op = 3'($urandom_range(0, 7));
      drv_exp = model(32, drv_a, drv_b, drv_op);
      step();
      if (c == 5) chk("stall_in_ready", last_rdy, 1'b0);
      if (last_acc) sent++;
      c++;
    end
    chk("stall_sent", sent, 8);
    drain();

    single(32'h7FFF_FFFF, 32'h1, 3'd2,
           mk(32'h8000_0000, 0, 0, 1));
    drv_clr = 1;
    single(32'h8000_0000, 32'h1, 3'd6,
           mk(32'h7FFF_FFFF, 1, 0, 1));
    chk("clr_set_wins", ovf_sticky, 1'b1);
    step();
    chk("clr_alone", ovf_sticky, 1'b0);
    drv_clr = 0;

    for (int i = 0; i < 400; i++) begin
      drv_valid = ($urandom_range(0, 3) != 0);
      drv_ordy  = ($urandom_range(0, 3) != 0);
      drv_clr   = ($urandom_range(0, 15) == 0);
      drv_a = pick(); drv_b = pick();
      drv_op = 3'($urandom_range(0, 7));
      drv_exp = model(32, drv_a, drv_b, drv_op);
      step();
    end
    drv_clr = 0;
    drain();

    run8(8'h80, 8'h80, 3'd2, mk(32'h0, 0, 1, 1));
    run8(8'h0F, 8'hF0, 3'd4, mk(32'h0, 0, 1, 0));
    run8(8'hAA, 8'hFF, 3'd3, mk(32'h55, 0, 0, 0));
    for (int i = 0; i < 20; i++) begin
      logic [7:0] ra, rb;
      logic [2:0] ro;
      ra = 8'($urandom);
      rb = 8'($urandom);
      ro = 3'($urandom_range(0, 7));
      run8(ra, rb, ro, model(8, {24'h0, ra}, {24'h0, rb}, ro));
    end

    $display("Simulation finished: %0d checks, %0d errors",
             n_chk, n_err);
    $finish;
  end

endmodule
